// File: rtl/input_frame_loader_if.sv
// Sample stream, network handshake and frame bus between the pixel source/network and the loader.
interface input_frame_loader_if #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned dataWidth  = 16,
    parameter int unsigned PIX_WIDTH  = 8
);
    logic                             s_valid;
    logic                             s_ready;
    logic [PIX_WIDTH-1:0]             s_data;
    logic                             s_last;
    logic                             done_in;
    logic [NUM_INPUTS*dataWidth-1:0]  in_bus;
    logic                             first;
    logic                             busy;
    logic                             frame_err;
    logic                             timeout;

    modport master (
        output s_valid, s_data, s_last, done_in,
        input  s_ready, in_bus, first, busy, frame_err, timeout
    );

    modport slave (
        input  s_valid, s_data, s_last, done_in,
        output s_ready, in_bus, first, busy, frame_err, timeout
    );
endinterface

// File: rtl/input_frame_loader.sv
// Packs unsigned pixel samples into fixed-point frames and hands complete frames to neural_net,
// loading the next frame while the network is still computing.
module input_frame_loader #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned dataWidth  = 16,
    parameter int unsigned frac_bits  = 11,
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input_frame_loader_if.slave   bus
);

    localparam int unsigned BUS_W = NUM_INPUTS * dataWidth;
    localparam int unsigned CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned EXT_W = dataWidth + PIX_WIDTH;
    localparam int unsigned LSH   = (frac_bits >= PIX_WIDTH) ? frac_bits - PIX_WIDTH : 0;
    localparam int unsigned RSH   = (frac_bits >= PIX_WIDTH) ? 0 : PIX_WIDTH - frac_bits;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [BUS_W-1:0]    shadow;
    logic [BUS_W-1:0]    in_bus_q;
    logic                first_q;
    logic                busy_q;
    logic                err_q;
    logic                tmo_q;
    logic [TMO_W-1:0]    tmo_cnt;

    logic                ready_c;
    logic                accept_c;
    logic                store_c;
    logic                cnt_inc_c;
    logic                cnt_clr_c;
    logic                err_c;
    logic                fire_c;
    logic                tmo_hit_c;
    logic [EXT_W-1:0]    ext_c;
    logic [dataWidth-1:0] word_c;

    // Zero-extended rescale of s/2^PIX_WIDTH into the network's Q format
    always_comb begin
        ext_c  = EXT_W'(bus.s_data);
        word_c = dataWidth'((ext_c << LSH) >> RSH);
    end

    // A done_in in the expiry cycle means the network answered in time
    always_comb begin
        tmo_hit_c = (TIMEOUT != 0) && busy_q && !bus.done_in && (tmo_cnt == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (accept_c && (cnt == CNT_LAST)) begin
                    state_nxt = bus.s_last ? HOLD : DRAIN;
                end
            end
            DRAIN: begin
                if (accept_c && bus.s_last) begin
                    state_nxt = LOAD;
                end
            end
            HOLD: begin
                if (fire_c) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // FSM outputs: handshake and datapath controls
    always_comb begin
        ready_c   = 1'b0;
        accept_c  = 1'b0;
        store_c   = 1'b0;
        cnt_inc_c = 1'b0;
        cnt_clr_c = 1'b0;
        err_c     = 1'b0;
        fire_c    = 1'b0;
        case (state)
            LOAD: begin
                ready_c  = !rst;
                accept_c = bus.s_valid && ready_c;
                if (accept_c) begin
                    store_c = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_clr_c = 1'b1;
                        err_c     = !bus.s_last;
                    end else if (bus.s_last) begin
                        cnt_clr_c = 1'b1;
                        err_c     = 1'b1;
                    end else begin
                        cnt_inc_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                ready_c   = !rst;
                accept_c  = bus.s_valid && ready_c;
                cnt_clr_c = accept_c && bus.s_last;
            end
            HOLD: begin
                fire_c = !busy_q || bus.done_in;
            end
            default: begin
                ready_c = 1'b0;
            end
        endcase
    end

    // Shadow packing, frame transfer, occupancy and timeout tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            shadow   <= '0;
            in_bus_q <= '0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            first_q <= fire_c;
            err_q   <= err_c;
            tmo_q   <= tmo_hit_c;

            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (store_c && (cnt == CNT_W'(k))) begin
                    shadow[k*dataWidth +: dataWidth] <= word_c;
                end
            end

            if (cnt_clr_c || fire_c) begin
                cnt <= '0;
            end else if (cnt_inc_c) begin
                cnt <= cnt + CNT_W'(1);
            end

            // A fire in the same cycle as done_in keeps the network busy
            if (fire_c) begin
                in_bus_q <= shadow;
                busy_q   <= 1'b1;
                tmo_cnt  <= '0;
            end else if (bus.done_in || tmo_hit_c) begin
                busy_q   <= 1'b0;
            end else if (busy_q && (TIMEOUT != 0)) begin
                tmo_cnt  <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign bus.s_ready   = ready_c;
    assign bus.in_bus    = in_bus_q;
    assign bus.first     = first_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = err_q;
    assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_input_frame_loader.sv
// Self-checking bench for input_frame_loader: directed scenarios followed by random traffic,
// all compared against a frame-level reference model.
module tb_input_frame_loader;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int FRAC = 11;
    localparam int PIX  = 8;
    localparam int TMO  = 8;
    localparam int BW   = N * DW;
    localparam int LSH  = (FRAC >= PIX) ? FRAC - PIX : 0;
    localparam int RSH  = (FRAC >= PIX) ? 0 : PIX - FRAC;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    input_frame_loader_if #(.NUM_INPUTS(N), .dataWidth(DW), .PIX_WIDTH(PIX)) bus ();

    input_frame_loader #(
        .NUM_INPUTS (N),
        .dataWidth  (DW),
        .frac_bits  (FRAC),
        .PIX_WIDTH  (PIX),
        .TIMEOUT    (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic            m_first, m_busy, m_err, m_tmo;
    logic [BW-1:0]   m_bus, m_pend_frame;
    bit              m_pending, m_drop;
    int              m_age;
    logic [DW-1:0]   m_q[$];

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] conv(input logic [PIX-1:0] p);
        int v;
        v = int'(p);
        v = (v * (1 << LSH)) / (1 << RSH);
        return DW'(v);
    endfunction

    task automatic model_reset();
        m_first = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_tmo = 1'b0;
        m_bus = '0; m_pend_frame = '0; m_pending = 1'b0; m_drop = 1'b0; m_age = 0;
        m_q.delete();
    endtask

    // One rising edge of the block, described in terms of frames, not states
    task automatic model_edge(input logic r, input logic v, input logic l, input logic dn,
                              input logic [PIX-1:0] d);
        bit acc, fire, hit;
        if (r) begin
            model_reset();
            return;
        end
        acc  = v && !m_pending;
        fire = m_pending && (!m_busy || dn);
        hit  = (TMO > 0) && m_busy && !dn && (m_age == TMO - 1);
        m_first = fire;
        m_err   = 1'b0;
        m_tmo   = hit;
        if (fire) begin
            m_bus     = m_pend_frame;
            m_busy    = 1'b1;
            m_age     = 0;
            m_pending = 1'b0;
        end else if (m_busy && (dn || hit)) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end
        if (acc) begin
            if (m_drop) begin
                if (l) m_drop = 1'b0;
            end else begin
                m_q.push_back(conv(d));
                if (l && m_q.size() == N) begin
                    m_pend_frame = '0;
                    for (int k = 0; k < N; k++) m_pend_frame[k*DW +: DW] = m_q[k];
                    m_pending = 1'b1;
                    m_q.delete();
                end else if (l) begin
                    m_err = 1'b1;
                    m_q.delete();
                end else if (m_q.size() == N) begin
                    m_err  = 1'b1;
                    m_drop = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic l, input logic dn,
                         input logic [PIX-1:0] d);
        rst         = r;
        bus.s_valid = v;
        bus.s_last  = l;
        bus.done_in = dn;
        bus.s_data  = d;
        #1;
        chk("s_ready", BW'(bus.s_ready), BW'(!r && !m_pending));
        @(posedge clk);
        model_edge(r, v, l, dn, d);
        #1;
        chk("first",     BW'(bus.first),     BW'(m_first));
        chk("busy",      BW'(bus.busy),      BW'(m_busy));
        chk("frame_err", BW'(bus.frame_err), BW'(m_err));
        chk("timeout",   BW'(bus.timeout),   BW'(m_tmo));
        chk("in_bus",    bus.in_bus,         m_bus);
    endtask

    task automatic send(input logic [PIX-1:0] d, input logic l);
        cycle(1'b0, 1'b1, l, 1'b0, d);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_fire();
        for (int i = 0; i < 20; i++) begin
            if (m_first) break;
            idle();
        end
        chk("fire_seen", BW'(bus.first), BW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic r, v, l, dn;
        logic [PIX-1:0] d;
        model_reset();

        // Reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_in_bus", bus.in_bus, '0);
        chk("rst_busy",   BW'(bus.busy), '0);

        // Conversion and packing
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd255, 1'b1);
        chk("no_early_first", BW'(bus.first), '0);
        idle();
        chk("pack_bus",   bus.in_bus, 64'h07F8_0018_0010_0008);
        chk("pack_first", BW'(bus.first), BW'(1));
        chk("pack_busy",  BW'(bus.busy), BW'(1));
        idle();
        chk("first_once", BW'(bus.first), '0);

        // Backpressure: frame loads while busy, fires on done_in
        idle();
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b1);
        chk("hold_ready", BW'(bus.s_ready), '0);
        idle();
        chk("bus_held", bus.in_bus, 64'h07F8_0018_0010_0008);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("bp_first", BW'(bus.first), BW'(1));
        chk("bp_busy",  BW'(bus.busy), BW'(1));
        chk("bp_bus",   bus.in_bus, 64'h0140_00F0_00A0_0050);

        // Short frame
        send(8'd9, 1'b0); send(8'd9, 1'b1);
        chk("short_err",      BW'(bus.frame_err), BW'(1));
        chk("short_no_first", BW'(bus.first), '0);
        send(8'd4, 1'b0); send(8'd4, 1'b0); send(8'd4, 1'b0); send(8'd4, 1'b1);
        wait_fire();
        chk("short_next_bus", bus.in_bus, 64'h0020_0020_0020_0020);

        // Long frame
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        chk("long_err", BW'(bus.frame_err), BW'(1));
        send(8'd5, 1'b0); send(8'd6, 1'b1);
        chk("long_no_err_drain", BW'(bus.frame_err), '0);
        chk("long_resume", BW'(bus.s_ready), BW'(1));
        send(8'd100, 1'b0); send(8'd101, 1'b0); send(8'd102, 1'b0); send(8'd103, 1'b1);
        wait_fire();
        chk("long_next_bus", bus.in_bus, 64'h0338_0330_0328_0320);

        // Timeout: no done_in after the fire
        send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b1);
        idle(); idle(); idle();
        idle();
        chk("tmo_pulse",    BW'(bus.timeout), BW'(1));
        chk("tmo_busy",     BW'(bus.busy), '0);
        chk("tmo_no_first", BW'(bus.first), '0);
        idle();
        chk("tmo_fire",     BW'(bus.first), BW'(1));
        chk("tmo_tmo_once", BW'(bus.timeout), '0);

        // Reset mid-load
        send(8'd50, 1'b0); send(8'd51, 1'b0); send(8'd52, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("mid_rst_bus",  bus.in_bus, '0);
        chk("mid_rst_busy", BW'(bus.busy), '0);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("ready_after_rst", BW'(bus.s_ready), BW'(1));
        send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b0); send(8'd8, 1'b1);
        wait_fire();
        chk("rst_next_bus", bus.in_bus, 64'h0040_0038_0030_0028);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 9) < 7);
            if (!m_drop && m_q.size() == N - 1)
                l = ($urandom_range(0, 9) < 8);
            else
                l = ($urandom_range(0, 19) == 0);
            dn = ($urandom_range(0, 4) == 0);
            d  = PIX'($urandom);
            cycle(r, v, l, dn, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
